// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO word offsets,
// default MMIO base and the byte-lane merge used by every writable word.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        MMIO_CNT_LO  = 2'd0,
        MMIO_CNT_HI  = 2'd1,
        MMIO_TOHOST  = 2'd2,
        MMIO_SCRATCH = 2'd3
    } mmio_off_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer64.sv
// Free-running 64-bit cycle counter with a high-half shadow captured on
// every low-half read, so a LO-then-HI read pair is consistent across a carry.
module mmio_timer64
    import dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lo_rd_i,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o,
    output logic [31:0] shadow_o
);

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q;

    // A write to either half suppresses the increment for that edge.
    always_comb begin
        cnt_d = cnt_q + 64'd1;
        if (lo_we_i) begin
            cnt_d = {cnt_q[63:32], byte_merge(cnt_q[31:0], wdata_i, wstrb_i)};
        end else if (hi_we_i) begin
            cnt_d = {byte_merge(cnt_q[63:32], wdata_i, wstrb_i), cnt_q[31:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (lo_rd_i) begin
                shadow_q <= cnt_q[63:32];
            end
        end
    end

    assign lo_o     = cnt_q[31:0];
    assign hi_o     = cnt_q[63:32];
    assign shadow_o = shadow_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM plus a 16-byte MMIO window (counter,
// tohost mailbox, scratch) with one-cycle write-first registered load data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        addr_err
);

    logic [31:0] mem [2**MEM_AW];

    logic [31:0] rdata_q, rdata_d;
    logic        tohost_valid_q;
    logic [31:0] tohost_q, scratch_q;
    logic        addr_err_q;

    logic            sram_hit, mmio_hit, wr;
    logic [MEM_AW-1:0] word_idx;
    mmio_off_e       off;
    logic            sram_we, tohost_we, scratch_we, cnt_lo_we, cnt_hi_we;
    logic            cnt_lo_rd, unmapped;
    logic [31:0]     cnt_lo, cnt_hi, cnt_shadow;

    assign sram_hit = (addr[31:MEM_AW+2] == '0);
    assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
    assign word_idx = addr[MEM_AW+1:2];
    assign off      = mmio_off_e'(addr[3:2]);
    assign wr       = |wstrb;

    mmio_timer64 u_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .lo_rd_i  (cnt_lo_rd),
        .lo_we_i  (cnt_lo_we),
        .hi_we_i  (cnt_hi_we),
        .wdata_i  (wdata),
        .wstrb_i  (wstrb),
        .lo_o     (cnt_lo),
        .hi_o     (cnt_hi),
        .shadow_o (cnt_shadow)
    );

    // Every cycle is a read; a concurrent write returns the merged word.
    always_comb begin
        rdata_d    = '0;
        sram_we    = 1'b0;
        tohost_we  = 1'b0;
        scratch_we = 1'b0;
        cnt_lo_we  = 1'b0;
        cnt_hi_we  = 1'b0;
        cnt_lo_rd  = 1'b0;
        unmapped   = 1'b0;
        if (sram_hit) begin
            rdata_d = byte_merge(mem[word_idx], wdata, wstrb);
            sram_we = wr;
        end else if (mmio_hit) begin
            unique case (off)
                MMIO_CNT_LO: begin
                    rdata_d   = byte_merge(cnt_lo, wdata, wstrb);
                    cnt_lo_we = wr;
                    cnt_lo_rd = 1'b1;
                end
                MMIO_CNT_HI: begin
                    rdata_d   = wr ? byte_merge(cnt_hi, wdata, wstrb) : cnt_shadow;
                    cnt_hi_we = wr;
                end
                MMIO_TOHOST: begin
                    rdata_d   = byte_merge(tohost_q, wdata, wstrb);
                    tohost_we = wr;
                end
                MMIO_SCRATCH: begin
                    rdata_d    = byte_merge(scratch_q, wdata, wstrb);
                    scratch_we = wr;
                end
            endcase
        end else begin
            unmapped = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && sram_we) begin
            mem[word_idx] <= byte_merge(mem[word_idx], wdata, wstrb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q        <= '0;
            tohost_valid_q <= 1'b0;
            tohost_q       <= '0;
            scratch_q      <= '0;
            addr_err_q     <= 1'b0;
        end else begin
            rdata_q        <= rdata_d;
            tohost_valid_q <= tohost_we;
            if (tohost_we) begin
                tohost_q <= byte_merge(tohost_q, wdata, wstrb);
            end
            if (scratch_we) begin
                scratch_q <= byte_merge(scratch_q, wdata, wstrb);
            end
            if (unmapped) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign rdata        = rdata_q;
    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_q;
    assign addr_err     = addr_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port.
- Accepts the core's address, byte-lane-aligned store data and 4-bit write strobes every cycle, and returns load data one cycle later. This one-cycle latency matches the core's load-stall timing.
- Backs a word-addressed SRAM region and a small MMIO window: a 64-bit cycle counter, a tohost mailbox and a scratch register.
- Sits beside the core at top level; replaces the behavioural data-memory model.

Parameters:
- MEM_AW, 12, word-address bits of the SRAM region (2^MEM_AW 32-bit words, based at 0x0000_0000).
- MMIO_BASE, 32'hFFFF_0000, base address of the 16-byte MMIO window.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  byte address from core ALU; addr[1:0] ignored for word select.
- wdata  input  32  store data, already shifted into byte lanes by the core.
- wstrb  input  4  byte write enables; 4'b0000 means read-only cycle.
- rdata  output  32  registered load data for the address presented the previous cycle.
- tohost_valid  output  1  one-cycle pulse after any write to the tohost register.
- tohost_data  output  32  current tohost register contents.
- addr_err  output  1  sticky flag: an access hit an unmapped address.

Behaviour:
- Reset (rst=1 at an edge): rdata=0, tohost_valid=0, tohost_data=0, addr_err=0, counter=0, shadow=0, scratch=0. SRAM contents are not reset.
- Decode:
  - SRAM when addr[31:MEM_AW+2]==0.
  - MMIO when addr[31:4]==MMIO_BASE[31:4].
  - Anything else is unmapped.
- MMIO offsets (addr[3:2]):
  - 0 = CNT_LO
  - 1 = CNT_HI (reads return the shadow)
  - 2 = TOHOST
  - 3 = SCRATCH
- Read latency: exactly 1 cycle. At edge N, rdata <= value(addr sampled at N). Reads happen every cycle with no request strobe.
- Same-cycle write+read to the same word: write-first. rdata holds the post-write merged word; unstrobed bytes keep their old values.
- Writes: each byte lane i is updated iff wstrb[i]; this applies identically to SRAM, TOHOST, SCRATCH and counter halves.
- Counter:
  - Free-running 64-bit; +1 every cycle and wraps 2^64-1 -> 0.
  - A read of CNT_LO returns the pre-increment count at that edge and copies count[63:32] into the shadow in the same edge.
  - A read of CNT_HI returns the shadow, so an LO-then-HI sequence is atomic across a carry.
  - A write to CNT_LO/CNT_HI loads the strobed bytes into that half. There is no increment on that edge; the other half is held.
- TOHOST: a write with wstrb!=0 merges into tohost_data; tohost_valid=1 in the following cycle only. Back-to-back writes give back-to-back pulses.
- Unmapped address:
  - Read returns 32'h0.
  - Write is dropped.
  - addr_err is set to 1 if wstrb!=0 or for any read, and stays set until rst.
- Reset mid-operation: rst overrides any same-edge write (including SRAM) and any tohost pulse. rdata=0 on the following cycle.
- No back-pressure; the block accepts a new access every cycle.

Decomposition:
- Shared package dmem_pkg:
  - MMIO offset constants (CNT_LO, CNT_HI, TOHOST, SCRATCH)
  - MMIO_BASE default
  - a byte-merge function (old word, new word, strobe) -> merged word
- One sub-module, mmio_timer64: 64-bit counter plus shadow register, with lo/hi read and write strobes. The top module holds the SRAM array, decode, write-first read mux and tohost/scratch registers.

Test Plan:
1. Store/load: write 32'hDEADBEEF with wstrb=4'hF to 0x0000_0010, then read 0x0000_0010 -> rdata=32'hDEADBEEF one cycle after the read address.
2. Byte lanes: after test 1, write wdata=32'h0000_AA00 with wstrb=4'b0010 to 0x0000_0011 -> later read gives 32'hDEADAAEF; the same-cycle read on that edge also gives 32'hDEADAAEF (write-first).
3. Counter carry: write CNT_LO=32'hFFFF_FFFE, CNT_HI=0, then wait 1 cycle and read CNT_LO -> 32'hFFFF_FFFF. A read of CNT_HI 3 cycles later -> 0 (shadow), while the live high half is 1.
4. Tohost: write 32'h1 to 0xFFFF_0008 -> tohost_valid high for exactly one cycle after the write edge, tohost_data=1. A second write immediately after -> a second consecutive pulse.
5. Unmapped: read 0x8000_0000 -> rdata=0, addr_err=1 and stays 1; a write there changes no SRAM or MMIO state.
6. Reset mid-op: assert rst on the same edge as a write of 32'h5555_5555 to 0xFFFF_000C -> SCRATCH reads 0. rdata, tohost_valid, addr_err and the counter are 0 after reset.
